// File: rtl/gray_pool_downsampler.sv
// -----------------------------------------------------------------------------
// gray_pool_downsampler
//
// Purpose:
//   Takes the 8-bit grayscale pixel stream in the VGA_CLK domain, crops a
//   (OUT_W*POOL) x (OUT_H*POOL) window starting at (CROP_X0, CROP_Y0), and
//   box-averages each POOL x POOL cell into one thumbnail pixel.
//   One accumulator per output column is enough: a cell row finishes on the
//   last line of that cell, so the column sums can be reused for the next row.
//
// Ports:
//   VGA_CLK      in   pixel clock, all logic on the rising edge
//   RST          in   synchronous active-high reset
//   VGA_VS       in   vertical sync, active-low (low = between frames)
//   READ_Request in   pixel valid strobe for iGray
//   iGray        in   grayscale pixel
//   oPix_Valid   out  one-cycle strobe: oPix/oPix_X/oPix_Y are valid
//   oPix         out  floor(cell sum / (POOL*POOL))
//   oPix_X       out  output column
//   oPix_Y       out  output row
//   oFrame_Done  out  one-cycle pulse the cycle after the last cell of a frame
// -----------------------------------------------------------------------------
module gray_pool_downsampler #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int CROP_X0 = 96,
   parameter int CROP_Y0 = 16,
   parameter int POOL    = 16,
   parameter int OUT_W   = 28,
   parameter int OUT_H   = 28,
   parameter int DATA_W  = 8
) (
   input  logic              VGA_CLK,
   input  logic              RST,
   input  logic              VGA_VS,
   input  logic              READ_Request,
   input  logic [DATA_W-1:0] iGray,
   output logic              oPix_Valid,
   output logic [DATA_W-1:0] oPix,
   output logic [4:0]        oPix_X,
   output logic [4:0]        oPix_Y,
   output logic              oFrame_Done
);

   localparam int LOG2_POOL = $clog2(POOL);
   localparam int CROP_W    = OUT_W * POOL;
   localparam int CROP_H    = OUT_H * POOL;
   localparam int ACC_W     = DATA_W + 2 * LOG2_POOL;
   localparam int XW        = $clog2(IMG_W);
   localparam int YW        = $clog2(IMG_H + 1);
   localparam int RWX       = $clog2(CROP_W);
   localparam int RWY       = $clog2(CROP_H);
   localparam int CXW       = RWX - LOG2_POOL;
   localparam int CYW       = RWY - LOG2_POOL;

   typedef enum logic [1:0] {
      S_WAIT_VS,
      S_ARM,
      S_ACTIVE,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic              r_vs_d;
   logic [ACC_W-1:0]  r_acc [OUT_W];

   logic              w_take;
   logic              w_in_crop;
   logic [RWX-1:0]    w_rel_x;
   logic [RWY-1:0]    w_rel_y;
   logic [CXW-1:0]    w_cx;
   logic [CYW-1:0]    w_cy;
   logic              w_cell_end;
   logic              w_last_cell;
   logic [ACC_W-1:0]  w_sum;

   // Sum of POOL*POOL pixels divided by POOL*POOL with floor: the top DATA_W
   // bits of the accumulator.
   function automatic logic [DATA_W-1:0] pool_avg(input logic [ACC_W-1:0] sum);
      return sum[ACC_W-1 -: DATA_W];
   endfunction

   // Pixels past the last active line are never counted.
   assign w_take    = READ_Request && VGA_VS && (r_y < YW'(IMG_H));

   assign w_in_crop = (r_x >= XW'(CROP_X0)) && (r_x < XW'(CROP_X0 + CROP_W)) &&
                      (r_y >= YW'(CROP_Y0)) && (r_y < YW'(CROP_Y0 + CROP_H));

   // Offsets only matter inside the window, where they fit in RWX/RWY bits.
   assign w_rel_x   = RWX'(r_x - XW'(CROP_X0));
   assign w_rel_y   = RWY'(r_y - YW'(CROP_Y0));
   assign w_cx      = w_rel_x[RWX-1:LOG2_POOL];
   assign w_cy      = w_rel_y[RWY-1:LOG2_POOL];

   assign w_cell_end  = (&w_rel_x[LOG2_POOL-1:0]) && (&w_rel_y[LOG2_POOL-1:0]);
   assign w_last_cell = (w_cx == CXW'(OUT_W - 1)) && (w_cy == CYW'(OUT_H - 1));

   assign w_sum     = r_acc[w_cx] + ACC_W'(iGray);

   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         r_state     <= S_WAIT_VS;
         r_x         <= '0;
         r_y         <= '0;
         r_vs_d      <= 1'b0;
         for (int i = 0; i < OUT_W; i++) begin
            r_acc[i] <= '0;
         end
         oPix_Valid  <= 1'b0;
         oPix        <= '0;
         oPix_X      <= '0;
         oPix_Y      <= '0;
         oFrame_Done <= 1'b0;
      end else begin
         r_vs_d      <= VGA_VS;
         oPix_Valid  <= 1'b0;
         oFrame_Done <= 1'b0;

         case (r_state)
            S_WAIT_VS: begin
               if (!VGA_VS) begin
                  r_state <= S_ARM;
               end
            end

            // A frame starts only on a VS rising edge. Coming back here from
            // DONE while VS is still high therefore waits out the rest of the
            // current frame instead of re-arming on its tail.
            S_ARM: begin
               if (VGA_VS && !r_vs_d) begin
                  r_state <= S_ACTIVE;
                  r_x     <= '0;
                  r_y     <= '0;
               end
            end

            S_ACTIVE: begin
               if (!VGA_VS) begin
                  // Short frame: drop partial sums so the next frame starts clean.
                  r_state <= S_ARM;
                  r_x     <= '0;
                  r_y     <= '0;
                  for (int i = 0; i < OUT_W; i++) begin
                     r_acc[i] <= '0;
                  end
               end else if (w_take) begin
                  if (r_x == XW'(IMG_W - 1)) begin
                     r_x <= '0;
                     r_y <= r_y + YW'(1);
                  end else begin
                     r_x <= r_x + XW'(1);
                  end

                  if (w_in_crop) begin
                     if (w_cell_end) begin
                        oPix_Valid   <= 1'b1;
                        oPix         <= pool_avg(w_sum);
                        oPix_X       <= 5'(w_cx);
                        oPix_Y       <= 5'(w_cy);
                        r_acc[w_cx]  <= '0;
                        if (w_last_cell) begin
                           r_state <= S_DONE;
                        end
                     end else begin
                        r_acc[w_cx]  <= w_sum;
                     end
                  end
               end
            end

            S_DONE: begin
               oFrame_Done <= 1'b1;
               r_state     <= S_ARM;
               r_x         <= '0;
               r_y         <= '0;
            end

            default: begin
               r_state <= S_WAIT_VS;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_pool_downsampler.sv
// -----------------------------------------------------------------------------
// tb_gray_pool_downsampler
//
// Drives directed frames into a reduced-geometry instance of the downsampler
// (40x30 image, 4x4 cells, 7x6 thumbnail) and compares every output cycle
// against a frame-level model: expected cell averages come from summing the
// driven image, expected strobe times from when each cell's last pixel was
// actually delivered.
// -----------------------------------------------------------------------------
module tb_gray_pool_downsampler;

   localparam int W  = 40;
   localparam int H  = 30;
   localparam int X0 = 5;
   localparam int Y0 = 3;
   localparam int P  = 4;
   localparam int OW = 7;
   localparam int OH = 6;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       vs   = 1'b1;
   logic       rreq = 1'b0;
   logic [7:0] gray = 8'd0;
   logic       vld;
   logic [7:0] pix;
   logic [4:0] px;
   logic [4:0] py;
   logic       fdone;

   gray_pool_downsampler #(
      .IMG_W   (W),
      .IMG_H   (H),
      .CROP_X0 (X0),
      .CROP_Y0 (Y0),
      .POOL    (P),
      .OUT_W   (OW),
      .OUT_H   (OH),
      .DATA_W  (8)
   ) dut (
      .VGA_CLK      (clk),
      .RST          (rst),
      .VGA_VS       (vs),
      .READ_Request (rreq),
      .iGray        (gray),
      .oPix_Valid   (vld),
      .oPix         (pix),
      .oPix_X       (px),
      .oPix_Y       (py),
      .oFrame_Done  (fdone)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cx;
      int cy;
      int val;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   img     [H][W];
   int   pix_cyc [H][W];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   strobes_f = 0;
   int   dones_f   = 0;
   int   n_exp_f   = 0;
   int   last_strobe = -10;
   int   hold_pix = 0;
   int   hold_x   = 0;
   int   hold_y   = 0;
   bit   chk_en   = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: plain floor average over the cell's pixels of the driven image.
   function automatic int cell_avg(input int cx, input int cy);
      int s = 0;
      for (int yy = 0; yy < P; yy++)
         for (int xx = 0; xx < P; xx++)
            s += img[Y0 + cy*P + yy][X0 + cx*P + xx];
      return s / (P*P);
   endfunction

   // 0: flat base; 1: 255 outside crop, 0 inside; 2: sparse cell pattern;
   // 3: gradient x[7:0]; 4: random.
   task automatic fill(input int mode, input int base);
      for (int yy = 0; yy < H; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            case (mode)
               0: img[yy][xx] = base;
               1: img[yy][xx] = (xx >= X0 && xx < X0 + OW*P &&
                                 yy >= Y0 && yy < Y0 + OH*P) ? 0 : 255;
               2: img[yy][xx] = 0;
               3: img[yy][xx] = xx & 255;
               default: img[yy][xx] = int'($urandom_range(0, 255));
            endcase
         end
      end
      if (mode == 2) begin
         for (int yy = 0; yy < P; yy++)
            for (int xx = 0; xx < P; xx++)
               img[Y0 + 5*P + yy][X0 + 3*P + xx] = 255;
         img[Y0 + 1][X0 + 2] = 15;
         img[Y0][X0 + 4]     = 31;
      end
   endtask

   // Compare process: every cycle, strobe contents/timing or held values.
   always @(negedge clk) begin
      if (chk_en) begin
         if (vld) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_strobe: got strobe at (%0d,%0d), expected none", px, py);
            end else begin
               cur = exp_q.pop_front();
               check("pix_val", int'(pix), cur.val);
               check("pix_x", int'(px), cur.cx);
               check("pix_y", int'(py), cur.cy);
               check("strobe_cycle", cyc, pix_cyc[Y0 + cur.cy*P + P - 1][X0 + cur.cx*P + P - 1]);
               hold_pix    = cur.val;
               hold_x      = cur.cx;
               hold_y      = cur.cy;
               last_strobe = cyc;
               strobes_f++;
            end
         end else begin
            check("hold_pix", int'(pix), hold_pix);
            check("hold_x", int'(px), hold_x);
            check("hold_y", int'(py), hold_y);
         end
         if (fdone) begin
            check("frame_done_cycle", cyc, last_strobe + 1);
            dones_f++;
         end
      end
   end

   // cut_line < H: VS abort at the start of that line, or (cut_rst) a 1-cycle
   // RST at pixel (cut_line, rst_x) with the frame continuing afterwards.
   task automatic run_frame(input int mode, input int base, input bit gaps,
                            input int cut_line, input bit cut_rst, input int rst_x);
      int nrows = 0;
      fill(mode, base);
      for (int cy = 0; cy < OH; cy++)
         if (Y0 + cy*P + P - 1 < cut_line) nrows++;
      exp_q.delete();
      for (int cy = 0; cy < nrows; cy++)
         for (int cx = 0; cx < OW; cx++)
            exp_q.push_back('{cx: cx, cy: cy, val: cell_avg(cx, cy)});
      n_exp_f   = nrows * OW;
      strobes_f = 0;
      dones_f   = 0;
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            pix_cyc[yy][xx] = -1;

      // Vertical blanking, with junk strobes that must be ignored.
      vs = 1'b0; rreq = 1'b1; gray = 8'hFF;
      repeat (3) @(negedge clk);
      vs = 1'b1; rreq = 1'b0;
      repeat (2) @(negedge clk);

      for (int yy = 0; yy < H; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            if (!cut_rst && yy == cut_line && xx == 0) begin
               vs = 1'b0; rreq = 1'b1; gray = 8'hFF;
               repeat (4) @(negedge clk);
               rreq = 1'b0;
               return;
            end
            if (gaps) begin
               while ($urandom_range(0, 9) < 3) begin
                  rreq = 1'b0;
                  @(negedge clk);
               end
            end
            if (cut_rst && yy == cut_line && xx == rst_x) begin
               rreq = 1'b0; rst = 1'b1;
               @(posedge clk);
               #1;
               rst = 1'b0;
               hold_pix = 0; hold_x = 0; hold_y = 0;
               check("rst_mid_pix", int'(pix), 0);
               check("rst_mid_vld", int'(vld), 0);
               @(negedge clk);
            end
            rreq = 1'b1;
            gray = 8'(img[yy][xx]);
            pix_cyc[yy][xx] = cyc + 1;
            @(negedge clk);
         end
         rreq = 1'b0;
         repeat (2) @(negedge clk);
      end
      rreq = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic frame_check(input string name, input int exp_done);
      repeat (3) @(negedge clk);
      check({name, "_strobes"}, strobes_f, n_exp_f);
      check({name, "_dones"}, dones_f, exp_done);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_vld", int'(vld), 0);
      check("reset_pix", int'(pix), 0);
      check("reset_x", int'(px), 0);
      check("reset_y", int'(py), 0);
      check("reset_done", int'(fdone), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Hand-computed values pinning the model.
      fill(0, 100);
      check("pin_flat", cell_avg(4, 2), 100);
      fill(1, 0);
      check("pin_crop_tl", cell_avg(0, 0), 0);
      check("pin_crop_br", cell_avg(OW-1, OH-1), 0);
      fill(2, 0);
      check("pin_cell_full", cell_avg(3, 5), 255);
      check("pin_cell_floor0", cell_avg(0, 0), 0);
      check("pin_cell_floor1", cell_avg(1, 0), 1);
      fill(3, 0);
      check("pin_grad_c0", cell_avg(0, 0), 6);
      check("pin_grad_c6", cell_avg(6, 2), 30);

      run_frame(0, 100, 1'b0, H, 1'b0, 0);
      frame_check("flat100", 1);
      run_frame(1, 0, 1'b0, H, 1'b0, 0);
      frame_check("crop_edges", 1);
      run_frame(2, 0, 1'b0, H, 1'b0, 0);
      frame_check("one_cell", 1);
      run_frame(0, 77, 1'b0, 14, 1'b0, 0);
      frame_check("vs_abort", 0);
      run_frame(0, 50, 1'b0, H, 1'b0, 0);
      frame_check("after_abort", 1);
      run_frame(3, 0, 1'b1, H, 1'b0, 0);
      frame_check("gradient_gaps", 1);
      run_frame(0, 200, 1'b1, 12, 1'b1, 20);
      frame_check("mid_reset", 0);
      run_frame(4, 0, 1'b1, H, 1'b0, 0);
      frame_check("after_reset", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
